// File: rtl/mem_byte_write_sequencer.sv
// Turns word-granular valid/ready requests into byte writes and word reads
// on a 256x8 byte-write / 32-bit-read memory, one memory access per cycle.
module mem_byte_write_sequencer (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [5:0]  req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_be,
   output logic [7:0]  mem_addr,
   output logic [7:0]  mem_wd,
   output logic        mem_we,
   output logic        mem_re,
   input  logic [31:0] mem_rd,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, WRITE, RD_ISSUE, RD_WAIT} state_t;

   state_t      state, state_nx;
   logic [5:0]  word_q, word_nx;
   logic [31:0] wdata_q, wdata_nx;
   logic [3:0]  pend_q, pend_nx;
   logic [7:0]  mem_addr_nx, mem_wd_nx;
   logic        mem_we_nx, mem_re_nx, resp_valid_nx;
   logic [31:0] resp_rdata_nx;
   logic [3:0]  sel_mask;
   logic [31:0] sel_data;
   logic [5:0]  sel_word;
   logic [1:0]  lane;

   // Handshake: a request transfers at a rising edge where req_valid && req_ready.
   assign req_ready = (state == IDLE) && !rst;
   assign busy      = (state != IDLE);

   always_comb begin
      state_nx      = state;
      word_nx       = word_q;
      wdata_nx      = wdata_q;
      pend_nx       = pend_q;
      mem_addr_nx   = mem_addr;
      mem_wd_nx     = mem_wd;
      mem_we_nx     = 1'b0;
      mem_re_nx     = 1'b0;
      resp_valid_nx = 1'b0;
      resp_rdata_nx = resp_rdata;

      // The first lane is issued straight from the request so mem_we rises the cycle after acceptance.
      sel_mask = (state == IDLE) ? req_be    : pend_q;
      sel_data = (state == IDLE) ? req_wdata : wdata_q;
      sel_word = (state == IDLE) ? req_addr  : word_q;
      lane     = 2'd0;
      for (int k = 3; k >= 0; k--) begin
         if (sel_mask[k]) lane = 2'(k);
      end

      case (state)
         IDLE: begin
            if (req_valid) begin
               word_nx  = req_addr;
               wdata_nx = req_wdata;
               pend_nx  = req_be;
               if (!req_write) begin
                  mem_re_nx   = 1'b1;
                  mem_addr_nx = {req_addr, 2'b00};
                  state_nx    = RD_ISSUE;
               end else if (req_be != 4'b0) begin
                  mem_we_nx   = 1'b1;
                  mem_addr_nx = {sel_word, lane};
                  mem_wd_nx   = sel_data[8*lane +: 8];
                  pend_nx     = sel_mask & ~(4'b0001 << lane);
                  state_nx    = WRITE;
               end
            end
         end
         WRITE: begin
            if (pend_q != 4'b0) begin
               mem_we_nx   = 1'b1;
               mem_addr_nx = {sel_word, lane};
               mem_wd_nx   = sel_data[8*lane +: 8];
               pend_nx     = sel_mask & ~(4'b0001 << lane);
            end else begin
               state_nx = IDLE;
            end
         end
         RD_ISSUE: state_nx = RD_WAIT;
         RD_WAIT: begin
            resp_valid_nx = 1'b1;
            resp_rdata_nx = mem_rd;
            state_nx      = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         word_q     <= '0;
         wdata_q    <= '0;
         pend_q     <= '0;
         mem_addr   <= '0;
         mem_wd     <= '0;
         mem_we     <= 1'b0;
         mem_re     <= 1'b0;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
      end else begin
         state      <= state_nx;
         word_q     <= word_nx;
         wdata_q    <= wdata_nx;
         pend_q     <= pend_nx;
         mem_addr   <= mem_addr_nx;
         mem_wd     <= mem_wd_nx;
         mem_we     <= mem_we_nx;
         mem_re     <= mem_re_nx;
         resp_valid <= resp_valid_nx;
         resp_rdata <= resp_rdata_nx;
      end
   end

endmodule

// File: tb/tb_mem_byte_write_sequencer.sv
// Directed and randomized checks of mem_byte_write_sequencer against a
// word-level reference memory, with a byte-write memory attached to the ports.
module tb_mem_byte_write_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_write;
   logic        req_ready;
   logic [5:0]  req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_be;
   logic [7:0]  mem_addr, mem_wd;
   logic        mem_we, mem_re;
   logic [31:0] mem_rd;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        busy;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0]  bmem [256];
   logic [31:0] ref_mem [64];

   mem_byte_write_sequencer dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_be     (req_be),
      .mem_addr   (mem_addr),
      .mem_wd     (mem_wd),
      .mem_we     (mem_we),
      .mem_re     (mem_re),
      .mem_rd     (mem_rd),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // Attached memory: byte write, registered 32-bit word read.
   always @(posedge clk) begin
      if (mem_we) bmem[mem_addr] <= mem_wd;
      if (mem_re) mem_rd <= {bmem[{mem_addr[7:2], 2'd3}], bmem[{mem_addr[7:2], 2'd2}],
                             bmem[{mem_addr[7:2], 2'd1}], bmem[{mem_addr[7:2], 2'd0}]};
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      check("never_both", {31'b0, mem_we & mem_re}, 32'd0);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_ready"}, {31'b0, req_ready}, 32'd0);
      check({tag, "_addr"}, {24'b0, mem_addr}, 32'd0);
      check({tag, "_wd"}, {24'b0, mem_wd}, 32'd0);
      check({tag, "_we"}, {31'b0, mem_we}, 32'd0);
      check({tag, "_re"}, {31'b0, mem_re}, 32'd0);
      check({tag, "_rvalid"}, {31'b0, resp_valid}, 32'd0);
      check({tag, "_rdata"}, resp_rdata, 32'd0);
      check({tag, "_busy"}, {31'b0, busy}, 32'd0);
   endtask

   task automatic do_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] be);
      check("wr_ready_before", {31'b0, req_ready}, 32'd1);
      req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = d; req_be = be;
      step();
      req_valid = 1'b0;
      if (be == 4'b0) begin
         check("noop_we", {31'b0, mem_we}, 32'd0);
         check("noop_re", {31'b0, mem_re}, 32'd0);
         check("noop_ready", {31'b0, req_ready}, 32'd1);
      end else begin
         for (int k = 0; k < 4; k++) begin
            if (be[k]) begin
               check("wr_we", {31'b0, mem_we}, 32'd1);
               check("wr_addr", {24'b0, mem_addr}, 32'(a) * 4 + 32'(k));
               check("wr_wd", {24'b0, mem_wd}, (d >> (8 * k)) & 32'hFF);
               check("wr_ready_low", {31'b0, req_ready}, 32'd0);
               step();
            end
         end
         check("wr_we_done", {31'b0, mem_we}, 32'd0);
         check("wr_ready_after", {31'b0, req_ready}, 32'd1);
      end
      for (int k = 0; k < 4; k++) begin
         if (be[k]) ref_mem[a][8*k +: 8] = d[8*k +: 8];
      end
   endtask

   task automatic do_read(input logic [5:0] a, input bit hold);
      check("rd_ready_before", {31'b0, req_ready}, 32'd1);
      req_valid = 1'b1; req_write = 1'b0; req_addr = a;
      req_wdata = $urandom; req_be = 4'($urandom);
      step();
      check("rd_re", {31'b0, mem_re}, 32'd1);
      check("rd_addr", {24'b0, mem_addr}, 32'(a) * 4);
      check("rd_ready_low", {31'b0, req_ready}, 32'd0);
      check("rd_rvalid_early", {31'b0, resp_valid}, 32'd0);
      if (hold) req_addr = 6'($urandom);
      else req_valid = 1'b0;
      step();
      check("rd_re_once", {31'b0, mem_re}, 32'd0);
      check("rd_busy", {31'b0, busy}, 32'd1);
      check("rd_rvalid_wait", {31'b0, resp_valid}, 32'd0);
      step();
      check("rd_rvalid", {31'b0, resp_valid}, 32'd1);
      check("rd_rdata", resp_rdata, ref_mem[a]);
      check("rd_ready_after", {31'b0, req_ready}, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d, old;
      for (int i = 0; i < 256; i++) bmem[i] = 8'h00;
      for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;
      mem_rd = 32'h0;
      rst = 1'b1; req_valid = 1'b0; req_write = 1'b0;
      req_addr = '0; req_wdata = '0; req_be = '0;

      repeat (2) @(posedge clk);
      #1;
      check_idle_outputs("reset");
      rst = 1'b0;
      step();
      check("ready_post_reset", {31'b0, req_ready}, 32'd1);

      do_write(6'd5, 32'hDDCCBBAA, 4'hF);
      do_write(6'h3F, 32'h44332211, 4'b1010);
      do_write(6'd7, 32'h12345678, 4'h0);
      do_read(6'd7, 1'b0);
      do_read(6'd5, 1'b0);
      step();
      check("rvalid_one_cycle", {31'b0, resp_valid}, 32'd0);
      check("rdata_held", resp_rdata, 32'hDDCCBBAA);

      // Reset during a full write: lanes 0-1 land, lanes 2-3 are dropped.
      old = $urandom;
      do_write(6'd9, old, 4'hF);
      d = $urandom;
      req_valid = 1'b1; req_write = 1'b1; req_addr = 6'd9; req_wdata = d; req_be = 4'hF;
      step();
      req_valid = 1'b0;
      check("rst_mid_lane0", {24'b0, mem_wd}, {24'b0, d[7:0]});
      step();
      check("rst_mid_lane1", {24'b0, mem_wd}, {24'b0, d[15:8]});
      step();
      rst = 1'b1;
      #1;
      check_idle_outputs("rst_mid");
      step();
      check_idle_outputs("rst_held");
      rst = 1'b0;
      #1;
      check("rst_mid_ready", {31'b0, req_ready}, 32'd1);
      ref_mem[9] = {old[31:16], d[15:0]};
      do_read(6'd9, 1'b0);

      // Back-to-back reads with req_valid held high.
      do_write(6'd0, $urandom, 4'($urandom));
      do_write(6'd1, $urandom, 4'hF);
      do_read(6'd0, 1'b1);
      do_read(6'd1, 1'b0);

      for (int i = 0; i < 24; i++) begin
         if ($urandom_range(0, 2) < 2) do_write(6'($urandom_range(0, 7)), $urandom, 4'($urandom));
         else do_read(6'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      end
      req_valid = 1'b0;
      for (int a = 0; a < 8; a++) do_read(6'(a), 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_byte_write_sequencer.md
# mem_byte_write_sequencer

Request-side sequencer that sits directly upstream of the 256x8 byte-write / 32-bit-read memory. It accepts word-granular requests (32-bit data, 4-bit byte enable, word address) over a valid/ready handshake and turns them into that memory's native port activity. Writes become one byte write per enabled lane; reads become a single word read whose result is captured and returned.
- The block never drives write-enable and read-enable in the same cycle, so the memory's same-cycle write-forwarding path is never relied upon.

## Interface
Parameters: none (memory geometry is fixed at 64 words x 4 bytes).

Ports:
- clk  in  1  rising-edge clock for all state
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request this cycle
- req_write  in  1  1 = write, 0 = read
- req_addr  in  6  word address
- req_wdata  in  32  write data; lane k = bits [8k+7:8k]
- req_be  in  4  byte enables, bit k enables lane k
- mem_addr  out  8  byte address to memory, {word, lane}
- mem_wd  out  8  byte write data to memory
- mem_we  out  1  memory write enable
- mem_re  out  1  memory read enable
- mem_rd  in  32  memory read word; valid the cycle after a mem_re cycle
- resp_valid  out  1  one-cycle pulse, resp_rdata valid
- resp_rdata  out  32  captured read word
- busy  out  1  high whenever state is not IDLE

## Operation
- States: IDLE, WRITE, RD_ISSUE, RD_WAIT.
- Acceptance:
  - req_ready = (state == IDLE).
  - A request is accepted at a clock edge where req_valid && req_ready.
  - On acceptance the block latches addr, wdata and be.
- Write path:
  - be != 0: go to WRITE.
  - In WRITE, issue exactly one byte per cycle for each set bit of the latched be, in ascending lane order. Cleared lanes are skipped and cost no cycles.
  - Each issue cycle drives mem_we=1, mem_addr={word, lane}, mem_wd = the lane's byte.
  - After the last enabled lane, return to IDLE.
- be == 0 write: the request is accepted as a no-op. No memory access occurs. The state stays IDLE, so req_ready remains high.
- Read path:
  - Accept, go to RD_ISSUE.
  - RD_ISSUE drives mem_re=1, mem_addr={word, 2'b00}, then goes to RD_WAIT.
  - RD_WAIT captures mem_rd into resp_rdata, pulses resp_valid, and goes to IDLE.
- mem_* outputs are registered. mem_addr and mem_wd hold their last value whenever mem_we and mem_re are both 0.
- Never both: mem_we and mem_re are never 1 in the same cycle.
- resp_rdata holds its value until the next read capture.
- Reset (asynchronous, any state, including mid-write):
  - State goes to IDLE; all outputs go to 0: req_ready=0 while rst is asserted, then 1 from the first cycle after deassertion.
  - Remaining lanes of an in-flight write are dropped. Bytes the memory already sampled stay written.

## Timing
- Edge E0: request accepted.
- Write with N enabled lanes (N = 1..4):
  - mem_we is high in the N cycles after E0, one lane per cycle.
  - req_ready is low for those N cycles and high again in cycle N+1.
  - Throughput: N+1 cycles per write.
- Read:
  - mem_re is high in cycle 1 (after E0). The memory samples at E1.
  - resp_valid and resp_rdata are valid in cycle 3 (after the capture at E2).
  - req_ready is high again in cycle 3, so back-to-back reads take 3 cycles each.
- Write-then-read to the same word: the read returns the new data. The last byte write lands at the edge where the state returns to IDLE, before the read's mem_re cycle.
- req_* inputs are ignored whenever req_ready = 0; holding req_valid high is permitted.
- Reset values: req_ready=0, mem_addr=0, mem_wd=0, mem_we=0, mem_re=0, resp_valid=0, resp_rdata=0, busy=0.

## Test plan
- **Full write:** write, addr=5, wdata=0xDDCCBBAA, be=4'hF.
  - Required: mem_we high 4 consecutive cycles with (mem_addr, mem_wd) = (0x14, 0xAA), (0x15, 0xBB), (0x16, 0xCC), (0x17, 0xDD); req_ready low for 4 cycles.
- **Sparse write:** write, addr=0x3F, wdata=0x44332211, be=4'b1010.
  - Required: exactly two write cycles, (0xFD, 0x22) then (0xFF, 0x44).
- **No-op write:** write, be=0.
  - Required: no mem_we/mem_re pulse; req_ready stays high; the next request is accepted the following cycle.
- **Write then read back:** after the full write, read addr=5.
  - Required: mem_re one cycle with mem_addr=0x14; 2 cycles later resp_valid=1 for one cycle with resp_rdata=0xDDCCBBAA; mem_we/mem_re never coincide.
- **Reset mid-write:** issue be=4'hF, assert rst after the 2nd byte.
  - Required: all outputs 0 immediately; only lanes 0-1 written; the next read of that word returns the new lanes 0-1 and the old lanes 2-3.
- **Back-to-back reads:** read addr=0 then addr=1 with req_valid held high.
  - Required: resp_valid pulses 3 cycles apart with the correct words; the second mem_re uses mem_addr=0x04.
